i2s_frame_tx: RTL and testbench
===============================

// Module: i2s_frame_tx
// PURPOSE
//  I2S transmitter that drains the eSRAM big FIFO's read port on the mclk domain.
//  - Issues one ren pulse per stereo frame.
//  - Captures the FIFO's 32-bit dout word (left = [31:16], right = [15:0]).
//  - Serialises the word as standard I2S: MSB-first, one-bclk delay after the lrck edge.
//  - Generates bclk and lrck by dividing mclk.
// PARAMETERS
//  BCLK_DIV   4   mclk cycles per bclk period; even, >= 2
//  SLOT_BITS  32  bclk cycles per channel slot; 17..32; bits after the 16 data bits are zero
//  CNTW       6   bit-counter width; 2**CNTW >= 2*SLOT_BITS
// PORTS
//  mclk         in   1   audio master clock, single clock domain
//  reset        in   1   asynchronous reset, active high
//  enable       in   1   run transmitter; low = hold idle
//  mute         in   1   send zero samples and stop pulling the FIFO
//  din          in   32  FIFO read data (bigfifo dout)
//  ren          out  1   FIFO read request, one-mclk pulse
//  bclk         out  1   I2S bit clock
//  lrck         out  1   I2S word select; 0 = left, 1 = right
//  sdata        out  1   I2S serial data
//  frame_start  out  1   one-mclk pulse at each frame boundary
// BEHAVIOUR
//  Reset: async on reset high. Every register and output is 0: ren, bclk, lrck, sdata, frame_start.
//  Internal state reset to 0: div_cnt, bit_cnt, next_word, shift_word, mute_f.
//  States:
//  - IDLE (enable=0): counters held at 0; all outputs forced 0 on the next mclk.
//  - RUN (enable=1): counters free-run from div_cnt=0, bit_cnt=0.
//  - IDLE->RUN takes effect on the first mclk edge where enable=1.
//  - RUN->IDLE takes effect on the first mclk edge where enable=0, including mid-frame.
//    The partial frame is abandoned; next_word is kept.
//  Counters (RUN):
//  - div_cnt counts 0..BCLK_DIV-1 and wraps.
//  - bit_cnt advances on each div_cnt wrap and counts 0..2*SLOT_BITS-1, then wraps.
//  - Frame = 2*SLOT_BITS*BCLK_DIV mclk cycles (256 at defaults).
//  bclk (registered):
//  - 0 while div_cnt < BCLK_DIV/2, 1 otherwise.
//  - The falling edge coincides with div_cnt==0. sdata and lrck change only there.
//  lrck: 0 when bit_cnt < SLOT_BITS, else 1.
//  Frame boundary (div_cnt==0, bit_cnt==0):
//  - frame_start=1 for that cycle.
//  - mute_f <= mute.
//  - shift_word <= mute ? 0 : next_word.
//  - ren=1 for that cycle if mute=0; otherwise ren=0.
//  Capture point (div_cnt==0, bit_cnt==SLOT_BITS):
//  - next_word <= din, only if the frame's ren was issued (mute_f=0).
//  - This is SLOT_BITS*BCLK_DIV mclk after ren (128 at defaults). That exceeds the FIFO read latency.
//  Latency: the word requested in frame N is played in frame N+1.
//  - The first frame after enable plays next_word: 0 after reset, otherwise the last captured word.
//  Serial mapping, for bit slot k:
//  - k=0: 0 (delay bit).
//  - k=1..16: shift_word[32-k] (left, MSB first).
//  - k=17..SLOT_BITS: 0.
//  - k=SLOT_BITS+1..SLOT_BITS+16: shift_word[16-(k-SLOT_BITS)] (right, MSB first).
//  - all other k: 0.
//  Simultaneous events:
//  - enable falling on a frame boundary wins: no ren, no load.
//  - mute changes are sampled only at frame boundaries. A mid-frame change never corrupts the current frame.
//  - reset has priority over everything.
//  FIFO underrun/empty is the FIFO's concern: it repeats or holds data, and this block plays whatever din holds.
//  Arithmetic: counters unsigned, wrap by compare-and-clear, never by overflow.
// TESTING (BCLK_DIV=4, SLOT_BITS=32)
//  1. reset, enable=1, din=32'hA5A5_3C3C constant
//     -> ren every 256 mclk.
//     -> frame 2: left slots 1..16 = A5A5, right slots 33..48 = 3C3C; all other slots 0.
//  2. Timing check -> bclk period 4 mclk, 50% duty; lrck toggles every 128 mclk; sdata/lrck change only on bclk fall.
//  3. mute=1 at bit_cnt=40
//     -> current frame unchanged.
//     -> next frame all zeros, no ren; ren resumes at the first boundary after mute=0.
//  4. enable=0 at bit_cnt=20
//     -> next mclk: all outputs 0.
//     -> re-enable: frame_start and ren on the first cycle; first frame replays the last captured word.
//  5. din=1111_2222 until bit_cnt=31, then 3333_4444 before the capture point -> next frame plays 3333_4444.
//  6. Async reset pulse mid-frame -> outputs 0 before the next mclk edge; restart equals the scenario 1 sequence.

Source files
------------

// File: rtl/i2s_frame_tx.sv
// I2S transmitter: pulls one 32-bit stereo word per frame from a FIFO read port
// and serialises it MSB-first with the standard one-bclk delay, all on mclk.
module i2s_frame_tx #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32,
  parameter int CNTW      = 6
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mute,
  input  logic [31:0] din,
  output logic        ren,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        frame_start
);

  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0]   DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [CNTW-1:0] SLOT     = CNTW'(SLOT_BITS);
  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(2 * SLOT_BITS - 1);

  logic [DW-1:0]   div_cnt;
  logic [CNTW-1:0] bit_cnt;
  logic [31:0]     next_word;
  logic [31:0]     shift_word;
  logic            mute_f;

  logic            div_wrap;
  logic            at_boundary;
  logic            at_capture;
  logic            ser_bit;
  logic [4:0]      left_idx;
  logic [4:0]      right_idx;

  assign div_wrap    = (div_cnt == DIV_LAST);
  assign at_boundary = (div_cnt == '0) && (bit_cnt == '0);
  assign at_capture  = (div_cnt == '0) && (bit_cnt == SLOT);
  assign left_idx    = 5'(CNTW'(32) - bit_cnt);
  assign right_idx   = 5'(CNTW'(16) - (bit_cnt - SLOT));

  // Slot 0 and SLOT_BITS carry the I2S delay bit; padding slots are zero.
  always_comb begin
    ser_bit = 1'b0;
    if (bit_cnt >= CNTW'(1) && bit_cnt <= CNTW'(16))
      ser_bit = shift_word[left_idx];
    else if (bit_cnt > SLOT && bit_cnt <= SLOT + CNTW'(16))
      ser_bit = shift_word[right_idx];
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      next_word   <= '0;
      shift_word  <= '0;
      mute_f      <= 1'b0;
      ren         <= 1'b0;
      bclk        <= 1'b0;
      lrck        <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      // Idle abandons any partial frame; next_word survives for the restart.
      div_cnt     <= '0;
      bit_cnt     <= '0;
      ren         <= 1'b0;
      bclk        <= 1'b0;
      lrck        <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap)
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      bclk        <= (div_cnt >= DIV_HALF);
      frame_start <= at_boundary;
      ren         <= at_boundary && !mute;
      if (div_cnt == '0) begin
        lrck  <= (bit_cnt >= SLOT);
        sdata <= ser_bit;
      end
      if (at_boundary) begin
        mute_f     <= mute;
        shift_word <= mute ? '0 : next_word;
      end
      // Half a frame after ren, the FIFO data is long settled.
      if (at_capture && !mute_f)
        next_word <= din;
    end
  end

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Bench for i2s_frame_tx: frame-position reference model, per-cycle output
// scoreboard and a bclk-rising-edge receiver that decodes whole frames.
module tb_i2s_frame_tx;
  localparam int BCLK_DIV  = 4;
  localparam int SLOT_BITS = 32;
  localparam int FRAME     = 2 * SLOT_BITS * BCLK_DIV;

  logic        mclk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mute;
  logic [31:0] din;
  logic        ren, bclk, lrck, sdata, frame_start;

  i2s_frame_tx #(.BCLK_DIV(BCLK_DIV), .SLOT_BITS(SLOT_BITS), .CNTW(6)) dut (
    .mclk(mclk), .reset(reset), .enable(enable), .mute(mute), .din(din),
    .ren(ren), .bclk(bclk), .lrck(lrck), .sdata(sdata), .frame_start(frame_start)
  );

  always #5 mclk = ~mclk;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state: position of the next enabled edge within a frame
  int          m_pos = 0;
  logic [31:0] m_next = '0;
  logic [31:0] m_play = '0;
  logic        m_mute_f = 1'b0;
  logic [4:0]  exp_q[$];

  // receiver
  logic [63:0] rx_sh = '0;
  logic [63:0] rx_last = '0;
  logic        bclk_prev = 1'b0;
  int          ren_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] slots(input logic [31:0] w);
    return {1'b0, w[31:16], 15'h0, 1'b0, w[15:0], 15'h0};
  endfunction

  task automatic step();
    logic [4:0]  e;
    logic [15:0] l, r;
    int          divk, bitk;
    e = '0;
    if (enable) begin
      divk = m_pos % BCLK_DIV;
      bitk = m_pos / BCLK_DIV;
      if (m_pos == 0) begin
        m_mute_f = mute;
        m_play   = mute ? 32'h0 : m_next;
      end
      l = m_play[31:16];
      r = m_play[15:0];
      e[4] = (m_pos == 0) && !mute;
      e[3] = (divk >= BCLK_DIV / 2);
      e[2] = (bitk >= SLOT_BITS);
      if (bitk >= 1 && bitk <= 16)
        e[1] = l[16 - bitk];
      else if (bitk >= SLOT_BITS + 1 && bitk <= SLOT_BITS + 16)
        e[1] = r[16 - (bitk - SLOT_BITS)];
      e[0] = (m_pos == 0);
      if (m_pos == SLOT_BITS * BCLK_DIV && !m_mute_f)
        m_next = din;
      m_pos = (m_pos + 1) % FRAME;
    end else begin
      m_pos = 0;
    end
    exp_q.push_back(e);
    @(posedge mclk);
    #1;
    check_val("outputs", {59'h0, ren, bclk, lrck, sdata, frame_start}, {59'h0, exp_q.pop_front()});
    if (frame_start) rx_last = rx_sh;
    if (!bclk_prev && bclk) rx_sh = {rx_sh[62:0], sdata};
    bclk_prev = bclk;
    if (ren) ren_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int pos, input string tag);
    int guard;
    guard = 0;
    while (m_pos != pos && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    if (m_pos != pos) check_val(tag, 64'(m_pos), 64'(pos));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mute = 1'b0; din = '0;
    @(posedge mclk);
    #1;
    check_val("reset_out", {59'h0, ren, bclk, lrck, sdata, frame_start}, 64'h0);
    #2 reset = 1'b0;

    // constant word: one ren per frame, frame 2 carries it
    din = 32'hA5A5_3C3C; enable = 1'b1; ren_cnt = 0;
    run(3 * FRAME);
    check_val("ren_per_frame", 64'(ren_cnt), 64'd3);
    check_val("frame2_slots", rx_last, slots(32'hA5A5_3C3C));

    // mute mid-frame
    run_to(160, "wait_mute");
    mute = 1'b1;
    run_to(0, "wait_mute_end");
    ren_cnt = 0;
    run(1);
    check_val("pre_mute_frame", rx_last, slots(32'hA5A5_3C3C));
    run_to(100, "wait_unmute");
    mute = 1'b0;
    run_to(0, "wait_muted_end");
    check_val("muted_no_ren", 64'(ren_cnt), 64'd0);
    run(1);
    check_val("muted_frame_zero", rx_last, 64'h0);
    check_val("ren_resumes", 64'(ren), 64'd1);

    // din changes before the capture point
    run_to(0, "wait_d5");
    din = 32'h1111_2222;
    run_to(124, "wait_bit31");
    din = 32'h3333_4444;
    run_to(0, "wait_d5_end");
    run(FRAME);
    run(1);
    check_val("late_din_frame", rx_last, slots(32'h3333_4444));

    // disable mid-frame and re-enable
    run_to(80, "wait_bit20");
    enable = 1'b0; din = 32'h5555_6666;
    run(1);
    check_val("idle_out", {59'h0, ren, bclk, lrck, sdata, frame_start}, 64'h0);
    run(5);
    enable = 1'b1;
    run(1);
    check_val("reenable_fs_ren", {62'h0, frame_start, ren}, 64'h3);
    run(FRAME - 1);
    run(1);
    check_val("replay_word", rx_last, slots(32'h3333_4444));

    // async reset mid-frame
    run_to(37, "wait_rst");
    reset = 1'b1;
    #1;
    check_val("async_reset", {59'h0, ren, bclk, lrck, sdata, frame_start}, 64'h0);
    m_pos = 0; m_next = '0; m_play = '0; m_mute_f = 1'b0;
    #2 reset = 1'b0;
    din = 32'hA5A5_3C3C; ren_cnt = 0;
    run(3 * FRAME);
    check_val("restart_ren", 64'(ren_cnt), 64'd3);
    check_val("restart_frame2", rx_last, slots(32'hA5A5_3C3C));

    // random FIFO data, mute and enable activity
    for (int i = 0; i < 5000; i++) begin
      din = $urandom;
      if ($urandom_range(0, 299) == 0) mute = ~mute;
      if (enable && $urandom_range(0, 799) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
